// File: rtl/uart_pkg.sv
// Shared types and register map for the register-mapped UART transmitter.
// Optional parity support is compiled in with UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic [4:0] ADDR_CPB  = 5'd0;
  localparam logic [4:0] ADDR_STOP = 5'd4;
  localparam logic [4:0] ADDR_PAR  = 5'd8;
  localparam logic [4:0] ADDR_TDR  = 5'd12;
  localparam logic [4:0] ADDR_CFG  = 5'd16;

  localparam int CFG_START = 0;
  localparam int CFG_BUSY  = 1;
  localparam int CFG_DONE  = 2;

endpackage

// File: rtl/uart_tx_regs_baud.sv
// Bit-period counter: counts 0..cpb while running, ticks on the last cycle.
// Cleared on frame launch so every frame starts on a full bit period.
module uart_baud_tick #(
  parameter int CPB_WIDTH = 16
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 run,
  input  logic [CPB_WIDTH-1:0] cpb,
  output logic                 tick
);

  logic [CPB_WIDTH-1:0] cnt;

  always_ff @(posedge clk_100MHz) begin
    if (reset || clear || !run) begin
      cnt <= '0;
    end else if (cnt == cpb) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CPB_WIDTH'(1);
    end
  end

  assign tick = run && (cnt == cpb);

endmodule

// File: rtl/uart_tx_regs.sv
// Register-mapped UART transmitter, one byte per CFG.START launch.
// Define UART_TX_PARITY_EN to add the PAR register and parity bit.
module uart_tx_regs
  import uart_pkg::*;
#(
  parameter int                   CPB_WIDTH = 16,
  parameter logic [CPB_WIDTH-1:0] CPB_RESET = 16'd867,
  parameter int                   DATA_BITS = 8
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        write_i,
  input  logic [3:0]  wstrb_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        rx_i,
  output logic        tx
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic [CPB_WIDTH-1:0] cpb_q;
  logic [1:0]           stop_q;
  logic [7:0]           tdr_q;
  logic                 start_q;
  logic                 done_q;

  uart_tx_state_t       state_q, state_n;
  logic [2:0]           idx_q, idx_n;
  logic                 stop2_q, stop2_n;
  logic                 frame_end;

  logic [CPB_WIDTH-1:0] sh_cpb;
  logic [DATA_BITS-1:0] sh_data;
  logic                 sh_two_stop;
  logic                 par_en;
  logic                 par_bit;

  logic busy, wr_cfg, launch, tick;
  logic unused_bits;

  assign busy   = (state_q != IDLE);
  assign wr_cfg = write_i && (addr_i == ADDR_CFG);
  assign launch = wr_cfg && wstrb_i[0] && wdata_i[0] && !busy;

  assign unused_bits = ^{rx_i, wdata_i, wstrb_i};

`ifdef UART_TX_PARITY_EN
  logic [1:0] par_q;
  logic [1:0] sh_par;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      par_q  <= 2'd0;
      sh_par <= 2'd0;
    end else begin
      if (write_i && addr_i == ADDR_PAR && wstrb_i[0]) begin
        par_q <= wdata_i[1:0];
      end
      if (launch) begin
        sh_par <= par_q;
      end
    end
  end

  assign par_en  = sh_par[0];
  assign par_bit = (^sh_data) ^ sh_par[1];
`else
  assign par_en  = 1'b0;
  assign par_bit = 1'b1;
`endif

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cpb_q   <= CPB_RESET;
      stop_q  <= 2'd1;
      tdr_q   <= 8'd0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (write_i) begin
        unique case (1'b1)
          addr_i == ADDR_CPB: begin
            for (int i = 0; i < CPB_WIDTH; i++) begin
              if (wstrb_i[i/8]) cpb_q[i] <= wdata_i[i];
            end
          end
          addr_i == ADDR_STOP: begin
            if (wstrb_i[0]) stop_q <= wdata_i[1:0];
          end
          addr_i == ADDR_TDR: begin
            if (wstrb_i[0]) tdr_q <= wdata_i[7:0];
          end
          addr_i == ADDR_CFG: begin
            if (wstrb_i[0]) start_q <= wdata_i[CFG_START];
          end
          default: ;
        endcase
      end
      // a frame finishing wins over a same-cycle CFG write clearing DONE
      if (frame_end) begin
        done_q <= 1'b1;
      end else if (wr_cfg) begin
        done_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      stop2_q     <= 1'b0;
      sh_cpb      <= CPB_RESET;
      sh_data     <= '0;
      sh_two_stop <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      stop2_q <= stop2_n;
      if (launch) begin
        sh_cpb      <= cpb_q;
        sh_data     <= tdr_q[DATA_BITS-1:0];
        sh_two_stop <= stop_q[1];
      end
    end
  end

  uart_baud_tick #(
    .CPB_WIDTH (CPB_WIDTH)
  ) u_baud (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clear      (launch),
    .run        (busy),
    .cpb        (sh_cpb),
    .tick       (tick)
  );

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    stop2_n   = stop2_q;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) state_n = START_BIT;
      end
      START_BIT: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_n = par_en ? PARITY : STOP;
            stop2_n = 1'b0;
          end else begin
            idx_n = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          stop2_n = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (sh_two_stop && !stop2_q) begin
            stop2_n = 1'b1;
          end else begin
            state_n   = IDLE;
            frame_end = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START_BIT: tx = 1'b0;
      DATA:      tx = sh_data[idx_q];
      PARITY:    tx = par_bit;
      default:   tx = 1'b1;
    endcase
  end

  always_comb begin
    rdata_o = 32'd0;
    unique case (1'b1)
      addr_i == ADDR_CPB:  rdata_o = 32'(cpb_q);
      addr_i == ADDR_STOP: rdata_o = {30'd0, stop_q};
`ifdef UART_TX_PARITY_EN
      addr_i == ADDR_PAR:  rdata_o = {30'd0, par_q};
`endif
      addr_i == ADDR_TDR:  rdata_o = {24'd0, tdr_q};
      addr_i == ADDR_CFG:  rdata_o = {29'd0, done_q, busy, start_q};
      default: rdata_o = 32'd0;
    endcase
  end

endmodule
